// File: rtl/yj_sync_fifo.sv
// Single-clock parametrised FIFO with count, almost-full/empty thresholds and sticky error flags.
// Define YJ_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module yj_sync_fifo #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 3,
  parameter int unsigned AF_LVL = 6,
  parameter int unsigned AE_LVL = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int unsigned Depth    = 2 ** AW;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);
  localparam logic [AW:0] AfLvl    = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AeLvl    = (AW + 1)'(AE_LVL);

  logic [DW-1:0] mem_q [Depth];
  logic [AW:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic          full_q, empty_q, almost_full_q, almost_empty_q;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          wa, ra;

  always_comb begin
    wa      = wr_en & ~full_q;
    ra      = rd_en & ~empty_q;
    count_d = count_q + {{AW{1'b0}}, wa} - {{AW{1'b0}}, ra};
    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (overflow_q & ~clr_err) | (wr_en & full_q);
    underflow_d = (underflow_q & ~clr_err) | (rd_en & empty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wa) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ra) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q        <= count_d;
      full_q         <= (count_d == DepthCnt);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AfLvl);
      almost_empty_q <= (count_d <= AeLvl);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wa) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifdef YJ_SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid = ~empty_q;
`else
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ra;
      if (ra) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_yj_sync_fifo.sv
// Directed bench for yj_sync_fifo at default parameters (DEPTH=8, AF_LVL=6, AE_LVL=1).
// Vector table covers reset/fill/drain/simultaneous ops; hand sequences cover wrap, mid-fill reset, FWFT.
module tb_yj_sync_fifo;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  yj_sync_fifo dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  typedef struct {
    logic        rst, we, re, clr;
    logic [31:0] wd;
    logic [3:0]  cnt;
    logic        ovf, unf, rv;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic we, logic [31:0] wd, logic re, logic clr,
                              logic [3:0] cnt, logic ovf, logic unf, logic rv, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.we = we; v.wd = wd; v.re = re; v.clr = clr;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.rv = rv; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic apply(logic rst, logic we, logic [31:0] wd, logic re, logic clr);
    RST = rst; wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_flags(string tag, logic [3:0] cnt);
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " full"}, 32'(full), 32'(cnt == 4'd8));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 4'd0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 4'd6));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 4'd1));
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  initial begin
`ifndef YJ_SYNC_FIFO_FWFT_EN
    // Reset, fill, overflow.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 32'(i), 0, 0, 4'(i + 1), 0, 0, 0, 0);
    add(0, 1, 32'hAA, 0, 0, 8, 1, 0, 0, 0);
    // Drain, underflow, clear.
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 0, 4'(7 - i), 1, 0, 1, 32'(i));
    add(0, 0, 0, 1, 0, 0, 1, 1, 0, 32'h7);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h7);
    // Simultaneous read/write at full: oldest word pops, write dropped.
    for (int i = 0; i < 8; i++) add(0, 1, 32'h10 + 32'(i), 0, 0, 4'(i + 1), 0, 0, 0, 32'h7);
    add(0, 1, 32'hEE, 1, 0, 7, 1, 0, 1, 32'h10);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 0, 4'(6 - i), 1, 0, 1, 32'h11 + 32'(i));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h17);
    // Simultaneous at empty: write accepted, read rejected.
    add(0, 1, 32'h33, 1, 0, 1, 0, 1, 0, 32'h17);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h33);
    add(0, 0, 0, 1, 1, 0, 0, 1, 0, 32'h33);  // set wins over clear
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h33);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      apply(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].clr);
      chk_flags(tag, vecs[i].cnt);
      chk({tag, " overflow"}, 32'(overflow), 32'(vecs[i].ovf));
      chk({tag, " underflow"}, 32'(underflow), 32'(vecs[i].unf));
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(vecs[i].rv));
      chk({tag, " rd_data"}, rd_data, vecs[i].rd);
    end

    // Wrap-around: 20 writes with steady-state concurrent reads, order preserved.
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic do_rd;
      do_rd = (i >= 3);
      if (do_rd) exp_word = exp_q.pop_front();
      exp_q.push_back(32'h100 + 32'(i));
      apply(0, 1, 32'h100 + 32'(i), do_rd, 0);
      chk($sformatf("wrap%0d count", i), 32'(count), (i < 3) ? 32'(i + 1) : 32'd3);
      if (do_rd) chk($sformatf("wrap%0d rd_data", i), rd_data, exp_word);
      chk($sformatf("wrap%0d rd_valid", i), 32'(rd_valid), 32'(do_rd));
    end
    for (int i = 0; i < 3; i++) begin
      exp_word = exp_q.pop_front();
      apply(0, 0, 0, 1, 0);
      chk($sformatf("wdrain%0d rd_data", i), rd_data, exp_word);
    end
    chk("wrap empty", 32'(empty), 32'd1);
    chk("wrap overflow", 32'(overflow), 32'd0);
    chk("wrap underflow", 32'(underflow), 32'd0);
`else
    // FWFT: written word appears without rd_en; rd_en pops it.
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 32'h5A, 0, 0);
    chk("fwft rd_valid", 32'(rd_valid), 32'd1);
    chk("fwft rd_data", rd_data, 32'h5A);
    chk_flags("fwft1", 1);
    apply(0, 0, 0, 0, 0);
    chk("fwft hold rd_data", rd_data, 32'h5A);
    apply(0, 0, 0, 1, 0);
    chk("fwft pop empty", 32'(empty), 32'd1);
    chk("fwft pop rd_valid", 32'(rd_valid), 32'd0);
    apply(0, 1, 32'h61, 0, 0);
    apply(0, 1, 32'h62, 0, 0);
    apply(0, 0, 0, 1, 0);
    chk("fwft second head", rd_data, 32'h62);
    chk("fwft underflow", 32'(underflow), 32'd0);
    apply(0, 0, 0, 1, 0);
`endif

    // Reset mid-fill discards queued data.
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(0, 1, 32'h40 + 32'(i), 0, 0);
    chk_flags("midfill", 4);
    apply(1, 1, 32'h99, 0, 0);
    chk_flags("midrst", 0);
    chk("midrst rd_valid", 32'(rd_valid), 32'd0);
    apply(0, 0, 0, 0, 0);
    chk_flags("postrst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
